// File: rtl/div_pkg.sv
// Shared widths, FSM encoding and helpers for the
// iterative integer divider.
package div_pkg;

  localparam int DIV_LEN       = 32;
  localparam int DIV_CNT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic logic [DIV_LEN-1:0] abs_val(
    input logic [DIV_LEN-1:0] v,
    input logic               sgn
  );
    return (sgn && v[DIV_LEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// One restoring-division step: shift {rem,quot}
// left, trial-subtract divisor, keep if no borrow.
module div_iter
  import div_pkg::*;
(
  input  logic [DIV_LEN-1:0] rem_in,
  input  logic [DIV_LEN-1:0] quot_in,
  input  logic [DIV_LEN-1:0] dvsr,
  output logic [DIV_LEN-1:0] rem_out,
  output logic [DIV_LEN-1:0] quot_out
);

  logic [DIV_LEN:0] shifted;
  logic [DIV_LEN:0] trial;
  logic             borrow;

  assign shifted = {rem_in, quot_in[DIV_LEN-1]};
  assign trial   = shifted - {1'b0, dvsr};
  // rem < dvsr, so a non-negative trial fits
  // in DIV_LEN bits and bit DIV_LEN is the borrow
  assign borrow  = trial[DIV_LEN];

  assign rem_out  = borrow ? shifted[DIV_LEN-1:0]
                           : trial[DIV_LEN-1:0];
  assign quot_out = {quot_in[DIV_LEN-2:0], ~borrow};

endmodule

// File: rtl/div.sv
// Multi-cycle signed/unsigned divider with RISC-V
// divide-by-zero and overflow results.
module div
  import div_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_LEN-1:0] div_op1,
  input  logic [DIV_LEN-1:0] div_op2,
  input  logic               div_signed,
  input  logic               div_start_en,
  input  logic               div_flush,
  output logic               div_busy,
  output logic               div_done,
  output logic [DIV_LEN-1:0] div_quot,
  output logic [DIV_LEN-1:0] div_rem
);

  localparam logic [DIV_CNT_WIDTH-1:0] CNT_LAST =
    DIV_CNT_WIDTH'(DIV_LEN - 1);
  localparam logic [DIV_LEN-1:0] MIN_NEG =
    {1'b1, {(DIV_LEN-1){1'b0}}};

  div_state_e               state;
  logic [DIV_CNT_WIDTH-1:0] cnt;
  logic [DIV_LEN-1:0]       dvsr;
  logic                     q_neg;
  logic                     r_neg;
  logic                     bypass;
  logic [DIV_LEN-1:0]       rem_nx;
  logic [DIV_LEN-1:0]       quot_nx;

  logic s1;
  logic s2;
  logic div_zero;
  logic ovf;

  assign s1       = div_signed & div_op1[DIV_LEN-1];
  assign s2       = div_signed & div_op2[DIV_LEN-1];
  assign div_zero = (div_op2 == '0);
  assign ovf      = div_signed
                  & (div_op1 == MIN_NEG)
                  & (div_op2 == '1);

  div_iter u_iter (
    .rem_in   (div_rem),
    .quot_in  (div_quot),
    .dvsr     (dvsr),
    .rem_out  (rem_nx),
    .quot_out (quot_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dvsr     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      bypass   <= 1'b0;
      div_busy <= 1'b0;
      div_done <= 1'b0;
      div_quot <= '0;
      div_rem  <= '0;
    end else if (div_flush) begin
      state    <= IDLE;
      cnt      <= '0;
      div_busy <= 1'b0;
      div_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          div_done <= 1'b0;
          if (div_start_en) begin
            div_busy <= 1'b1;
            cnt      <= '0;
            if (div_zero) begin
              div_quot <= '1;
              div_rem  <= div_op1;
              bypass   <= 1'b1;
              state    <= FIX;
            end else if (ovf) begin
              div_quot <= MIN_NEG;
              div_rem  <= '0;
              bypass   <= 1'b1;
              state    <= FIX;
            end else begin
              div_quot <= abs_val(div_op1, div_signed);
              div_rem  <= '0;
              dvsr     <= abs_val(div_op2, div_signed);
              q_neg    <= s1 ^ s2;
              r_neg    <= s1;
              bypass   <= 1'b0;
              state    <= CALC;
            end
          end else begin
            div_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        CALC: begin
          div_quot <= quot_nx;
          div_rem  <= rem_nx;
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            state <= FIX;
        end
        FIX: begin
          // Signs are only set in signed mode, and the
          // bypass results are already final
          if (!bypass && q_neg)
            div_quot <= -div_quot;
          if (!bypass && r_neg)
            div_rem <= -div_rem;
          div_done <= 1'b1;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed scoreboard bench for the divider:
// results, latency, bypasses, flush, ignored start.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_signed;
  logic        div_start_en;
  logic        div_flush;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  typedef struct {
    logic [31:0] quot;
    logic [31:0] rem;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   t0   = 0;

  always #5 clk = ~clk;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .div_op1      (div_op1),
    .div_op2      (div_op2),
    .div_signed   (div_signed),
    .div_start_en (div_start_en),
    .div_flush    (div_flush),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_quot     (div_quot),
    .div_rem      (div_rem)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Drives start for one cycle; t0 marks cycle t
  task automatic drive_start(input logic [31:0] a,
                             input logic [31:0] b,
                             input logic s);
    div_op1      = a;
    div_op2      = b;
    div_signed   = s;
    div_start_en = 1'b1;
    t0           = cyc;
    tick();
    div_start_en = 1'b0;
  endtask

  task automatic start_op(input logic [31:0] a,
                          input logic [31:0] b,
                          input logic s,
                          input logic [31:0] eq,
                          input logic [31:0] er,
                          input int lat);
    exp_t e;
    e.quot = eq;
    e.rem  = er;
    e.lat  = lat;
    sb.push_back(e);
    drive_start(a, b, s);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   lat;
    int   n;
    n = 0;
    while (div_done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    lat = cyc - t0;
    if (sb.size() == 0) begin
      nchk++;
      nerr++;
      $error("FAIL %s_sb: got empty expected entry",
             tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_quot"}, div_quot, e.quot);
      chk({tag, "_rem"}, div_rem, e.rem);
      chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    end
    tick();
    chk({tag, "_pulse"}, {31'd0, div_done}, 32'd0);
  endtask

  initial begin
    int dones;
    rst          = 1'b1;
    div_op1      = '0;
    div_op2      = '0;
    div_signed   = 1'b0;
    div_start_en = 1'b0;
    div_flush    = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, div_busy}, 32'd0);
    chk("rst_done", {31'd0, div_done}, 32'd0);
    chk("rst_quot", div_quot, 32'd0);
    chk("rst_rem", div_rem, 32'd0);
    rst = 1'b0;
    tick();

    start_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34);
    wait_done("u100_7");

    start_op(-32'sd7, 32'd2, 1'b1,
             32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    wait_done("s-7_2");

    start_op(32'd5, 32'd0, 1'b0,
             32'hFFFF_FFFF, 32'd5, 2);
    wait_done("u5_0");

    start_op(32'd5, 32'd0, 1'b1,
             32'hFFFF_FFFF, 32'd5, 2);
    wait_done("s5_0");

    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
             32'h8000_0000, 32'd0, 2);
    wait_done("s_ovf");

    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
             32'd0, 32'h8000_0000, 34);
    wait_done("u_ovf");

    start_op(32'd0, 32'd3, 1'b1, 32'd0, 32'd0, 34);
    wait_done("s0_3");

    // Flush at t+10, restart at t+11, done at t+45
    dones = 0;
    drive_start(32'd77, 32'd5, 1'b0);
    while (cyc < t0 + 10) begin
      if (div_done === 1'b1) dones++;
      tick();
    end
    div_flush = 1'b1;
    tick();
    div_flush = 1'b0;
    if (div_done === 1'b1) dones++;
    chk("flush_busy", {31'd0, div_busy}, 32'd0);
    start_op(32'd1000, 32'd33, 1'b0,
             32'd30, 32'd10, 34);
    chk("flush_nodone", 32'(dones), 32'd0);
    wait_done("restart");

    // Start re-asserted at t+5 must be ignored
    start_op(32'hFFFF_FFFF, 32'd16, 1'b0,
             32'h0FFF_FFFF, 32'd15, 34);
    while (cyc < t0 + 5) tick();
    div_op1      = 32'd9;
    div_op2      = 32'd3;
    div_start_en = 1'b1;
    tick();
    div_start_en = 1'b0;
    wait_done("ignore");

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
